instr_feeder: RTL

Program sequencer that sits directly upstream of the `top` processor. It holds a small loadable program memory and drives the processor's `din` and `run` inputs, one word per step: the instruction word at processor step t0 and, for MVI, the immediate at t1. It advances only on the processor's `done`, so the processor can execute a stored program with no external stimulus. It also flags timeouts, illegal opcodes and truncated programs.

---
 rtl/instr_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_feeder.sv
// instr_feeder: program sequencer placed upstream of the processor.
// Holds a loadable program memory and presents one word per processor step
// on din: the instruction at t0 and, for MVI, the immediate at t1. It moves
// to the next word only when the processor reports done.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   load_en/addr/data     program memory write port (ignored while busy)
//   prog_len              program length in words, latched on accepted start
//   start                 run from address 0 (accepted in IDLE/HALT only)
//   done                  processor step complete
//   din, run              word and run strobe driven to the processor
//   pc                    address of the word currently on din
//   busy, halted          status flags
//   err, err_code         sticky error: 01 timeout, 10 illegal op, 11 truncated MVI
module instr_feeder #(
    parameter int REG_WIDTH         = 16,
    parameter int INSTRUCTION_WIDTH = 9,
    parameter int ADDR_WIDTH        = 5,
    parameter int WAIT_LIMIT        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [REG_WIDTH-1:0]  load_data,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  start,
    input  logic                  done,
    output logic [REG_WIDTH-1:0]  din,
    output logic                  run,
    output logic [ADDR_WIDTH:0]   pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int WD_W  = $clog2(WAIT_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_IMM,
        S_WAIT,
        S_HALT
    } state_t;

    state_t                 state, state_n;
    logic [REG_WIDTH-1:0]   din_n;
    logic [ADDR_WIDTH:0]    pc_n, len, len_n, pc_inc;
    logic [WD_W-1:0]        wd, wd_n;
    logic                   err_n;
    logic [1:0]             err_code_n;
    logic [2:0]             opcode;

    logic [REG_WIDTH-1:0]   mem [0:DEPTH-1];

    assign busy   = (state == S_INSTR) || (state == S_IMM) || (state == S_WAIT);
    assign run    = busy;
    assign halted = (state == S_HALT);
    assign pc_inc = pc + 1'b1;
    assign opcode = din[INSTRUCTION_WIDTH-1 -: 3];

    // Program memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (load_en && !busy)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            din      <= '0;
            pc       <= '0;
            len      <= '0;
            wd       <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state    <= state_n;
            din      <= din_n;
            pc       <= pc_n;
            len      <= len_n;
            wd       <= wd_n;
            err      <= err_n;
            err_code <= err_code_n;
        end
    end

    always_comb begin
        state_n    = state;
        din_n      = din;
        pc_n       = pc;
        len_n      = len;
        wd_n       = wd;
        err_n      = err;
        err_code_n = err_code;

        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    len_n      = prog_len;
                    pc_n       = '0;
                    err_n      = 1'b0;
                    err_code_n = 2'b00;
                    if (prog_len == '0) begin
                        state_n = S_HALT;
                        din_n   = '0;
                    end else begin
                        state_n = S_INSTR;
                        din_n   = mem[0];
                    end
                end
            end

            S_INSTR: begin
                if (opcode == 3'b001) begin
                    if (pc_inc < len) begin
                        state_n = S_IMM;
                        pc_n    = pc_inc;
                        din_n   = mem[pc_inc[ADDR_WIDTH-1:0]];
                    end else begin
                        state_n    = S_HALT;
                        din_n      = '0;
                        err_n      = 1'b1;
                        err_code_n = 2'b11;
                    end
                end else if (opcode[2]) begin
                    state_n    = S_HALT;
                    din_n      = '0;
                    err_n      = 1'b1;
                    err_code_n = 2'b10;
                end else begin
                    state_n = S_WAIT;
                    wd_n    = '0;
                end
            end

            S_IMM, S_WAIT: begin
                if (done) begin
                    if (pc_inc < len) begin
                        state_n = S_INSTR;
                        pc_n    = pc_inc;
                        din_n   = mem[pc_inc[ADDR_WIDTH-1:0]];
                    end else begin
                        state_n = S_HALT;
                        din_n   = '0;
                    end
                end else if (state == S_IMM) begin
                    // An immediate without done simply starts the wait window.
                    state_n = S_WAIT;
                    wd_n    = '0;
                end else if (wd + 1'b1 == WD_LIM) begin
                    state_n    = S_HALT;
                    din_n      = '0;
                    err_n      = 1'b1;
                    err_code_n = 2'b01;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule
